// File: rtl/cgra_config_loader.sv
// Purpose: streams WORD_W-bit config words MSB-first into the CGRA scan chain, then releases the fabric for a programmed run.
// Latency: a word accepted in cycle k shows its first bit in cycle k+1; at least WORD_W+1 cycles per full word.
// Backpressure: in_ready is high only in LOAD; a missing word stalls the chain with config_enable low and no bit lost.
// Optional build macro CFG_CHECKSUM_EN: XOR checksum of the loaded words must match expected_sum before RUN.
module cgra_config_loader #(
    parameter int TOTAL_NUM_BITS = 465,
    parameter int WORD_W         = 32,
    parameter int RUN_W          = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [RUN_W-1:0]  run_cycles,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              config_bitstream,
    output logic              config_enable,
    output logic              cgra_reset,
    output logic              busy,
    output logic              config_done,
    output logic              run_done
`ifdef CFG_CHECKSUM_EN
    ,
    input  logic [WORD_W-1:0] expected_sum,
    output logic              checksum_ok
`endif
);

    localparam int BCW = $clog2(TOTAL_NUM_BITS + 1);
    localparam int BLW = $clog2(WORD_W + 1);

    localparam logic [BCW-1:0]   TOTAL_C = BCW'(TOTAL_NUM_BITS);
    localparam logic [BCW-1:0]   BC_ONE  = BCW'(1);
    localparam logic [BLW-1:0]   BL_ONE  = BLW'(1);
    localparam logic [BLW-1:0]   WORD_C  = BLW'(WORD_W);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    // Datapath registers: sreg[WORD_W-1] is always the bit currently on config_bitstream.
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] sreg_nx;
    logic [BLW-1:0]    bits_left;
    logic [BLW-1:0]    bits_left_nx;
    logic [BCW-1:0]    bit_count;
    logic [BCW-1:0]    bit_count_nx;
    logic [RUN_W-1:0]  run_len;
    logic [RUN_W-1:0]  run_len_nx;
    logic [RUN_W-1:0]  run_cnt;
    logic [RUN_W-1:0]  run_cnt_nx;

    // Next values of the registered outputs.
    logic bs_nx;
    logic en_nx;
    logic crst_nx;
    logic busy_nx;
    logic cdone_nx;
    logic rdone_nx;

    // Bits of the chain still unloaded, and how many of them the next word carries.
    logic [BCW-1:0] remaining;
    logic [BLW-1:0] word_len;

`ifdef CFG_CHECKSUM_EN
    logic [WORD_W-1:0] csum;
    logic [WORD_W-1:0] csum_nx;
    logic [WORD_W-1:0] word_mask;
    logic              ok_nx;
`endif

    // The only combinational output: the loader takes a word exactly while waiting in LOAD.
    assign in_ready = (state == LOAD);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, datapath and output decode; abort is applied last so it overrides everything.
    always_comb begin
        state_nx     = state;
        sreg_nx      = sreg;
        bits_left_nx = bits_left;
        bit_count_nx = bit_count;
        run_len_nx   = run_len;
        run_cnt_nx   = run_cnt;
        bs_nx        = 1'b0;
        en_nx        = 1'b0;
        crst_nx      = cgra_reset;
        busy_nx      = busy;
        cdone_nx     = config_done;
        rdone_nx     = run_done;

        remaining    = TOTAL_C - bit_count;
        word_len     = (32'(remaining) >= 32'(WORD_W)) ? WORD_C : BLW'(remaining);

`ifdef CFG_CHECKSUM_EN
        csum_nx      = csum;
        ok_nx        = checksum_ok;
        // Keep only the bits of this word that will actually reach the chain.
        word_mask    = {WORD_W{1'b1}} << (WORD_C - word_len);
`endif

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx     = LOAD;
                    run_len_nx   = run_cycles;
                    run_cnt_nx   = '0;
                    bit_count_nx = '0;
                    bits_left_nx = '0;
                    cdone_nx     = 1'b0;
                    rdone_nx     = 1'b0;
                    crst_nx      = 1'b1;
                    busy_nx      = 1'b1;
`ifdef CFG_CHECKSUM_EN
                    csum_nx      = '0;
                    ok_nx        = 1'b0;
`endif
                end
            end

            LOAD: begin
                // Without a word the chain simply pauses; enable stays low.
                if (in_valid) begin
                    state_nx     = SHIFT;
                    sreg_nx      = in_data;
                    bits_left_nx = word_len;
                    bs_nx        = in_data[WORD_W-1];
                    en_nx        = 1'b1;
`ifdef CFG_CHECKSUM_EN
                    csum_nx      = csum ^ (in_data & word_mask);
`endif
                end
            end

            SHIFT: begin
                // The bit on the output this cycle is consumed at this edge.
                bit_count_nx = bit_count + BC_ONE;
                bits_left_nx = bits_left - BL_ONE;
                sreg_nx      = {sreg[WORD_W-2:0], 1'b0};
                if (bits_left == BL_ONE) begin
                    if (bit_count_nx == TOTAL_C) begin
                        cdone_nx   = 1'b1;
                        run_cnt_nx = '0;
`ifdef CFG_CHECKSUM_EN
                        if (csum == expected_sum) begin
                            ok_nx    = 1'b1;
                            state_nx = RUN;
                            crst_nx  = 1'b0;
                        end else begin
                            // A corrupted bitstream must never be released into the fabric.
                            ok_nx    = 1'b0;
                            state_nx = IDLE;
                            crst_nx  = 1'b1;
                            busy_nx  = 1'b0;
                        end
`else
                        state_nx   = RUN;
                        crst_nx    = 1'b0;
`endif
                    end else begin
                        state_nx = LOAD;
                    end
                end else begin
                    bs_nx = sreg[WORD_W-2];
                    en_nx = 1'b1;
                end
            end

            RUN: begin
                // A zero run length still spends one cycle in RUN.
                if ((run_len == '0) || (run_cnt == run_len - RUN_ONE)) begin
                    state_nx = DONE;
                    rdone_nx = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    run_cnt_nx = run_cnt + RUN_ONE;
                end
            end

            default: begin
                state_nx = IDLE;
                crst_nx  = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase

        if (abort) begin
            state_nx = IDLE;
            bs_nx    = 1'b0;
            en_nx    = 1'b0;
            crst_nx  = 1'b1;
            busy_nx  = 1'b0;
            cdone_nx = 1'b0;
            rdone_nx = 1'b0;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sreg             <= '0;
            bits_left        <= '0;
            bit_count        <= '0;
            run_len          <= '0;
            run_cnt          <= '0;
            config_bitstream <= 1'b0;
            config_enable    <= 1'b0;
            cgra_reset       <= 1'b1;
            busy             <= 1'b0;
            config_done      <= 1'b0;
            run_done         <= 1'b0;
        end else begin
            sreg             <= sreg_nx;
            bits_left        <= bits_left_nx;
            bit_count        <= bit_count_nx;
            run_len          <= run_len_nx;
            run_cnt          <= run_cnt_nx;
            config_bitstream <= bs_nx;
            config_enable    <= en_nx;
            cgra_reset       <= crst_nx;
            busy             <= busy_nx;
            config_done      <= cdone_nx;
            run_done         <= rdone_nx;
        end
    end

`ifdef CFG_CHECKSUM_EN
    // Running checksum and its verdict, taken when the last bit leaves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum        <= '0;
            checksum_ok <= 1'b0;
        end else begin
            csum        <= csum_nx;
            checksum_ok <= ok_nx;
        end
    end
`endif

endmodule

// File: tb/tb_cgra_config_loader.sv
// Bench for cgra_config_loader: random and directed bitstreams checked against a bit-queue model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every wait on the design is bounded by a cycle budget.
`timescale 1ns/1ps
module tb_cgra_config_loader;

    localparam int TOTAL  = 465;
    localparam int W      = 32;
    localparam int RW     = 32;
    localparam int NWORDS = (TOTAL + W - 1) / W;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [RW-1:0] run_cycles;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          config_bitstream;
    logic          config_enable;
    logic          cgra_reset;
    logic          busy;
    logic          config_done;
    logic          run_done;
`ifdef CFG_CHECKSUM_EN
    logic [W-1:0]  expected_sum;
    logic          checksum_ok;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cgra_config_loader #(
        .TOTAL_NUM_BITS(TOTAL),
        .WORD_W(W),
        .RUN_W(RW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .abort(abort),
        .run_cycles(run_cycles),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .config_bitstream(config_bitstream),
        .config_enable(config_enable),
        .cgra_reset(cgra_reset),
        .busy(busy),
        .config_done(config_done),
        .run_done(run_done)
`ifdef CFG_CHECKSUM_EN
        ,
        .expected_sum(expected_sum),
        .checksum_ok(checksum_ok)
`endif
    );

    // Stimulus words and reference model state.
    logic [W-1:0] words [NWORDS];
    bit           exp_bits [$];
    logic [W-1:0] exp_sum;

    // Observations gathered by tick().
    bit cap_bits [$];
    int ncyc;
    int en_cnt, first_en, last_en, done_first, first_acc, run_low, off_bit_err;
    bit last_acc;

    task automatic mon_clear();
        cap_bits.delete();
        en_cnt      = 0;
        first_en    = -1;
        last_en     = -1;
        done_first  = -1;
        first_acc   = -1;
        run_low     = 0;
        off_bit_err = 0;
    endtask

    // One clock cycle: sample on the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clock);
        last_acc = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (last_acc && first_acc < 0) first_acc = ncyc;
        if (config_enable === 1'b1) begin
            cap_bits.push_back(config_bitstream);
            en_cnt++;
            if (first_en < 0) first_en = ncyc;
            last_en = ncyc;
        end else if (config_bitstream !== 1'b0) begin
            off_bit_err++;
        end
        if (config_done === 1'b1 && done_first < 0) done_first = ncyc;
        if (cgra_reset === 1'b0 && run_done === 1'b0) run_low++;
        @(posedge clock);
        #1;
        ncyc++;
    endtask

    // Reference model: the chain receives each word MSB first and stops after TOTAL bits;
    // the checksum is the XOR of all words with the never-shifted tail bits zeroed.
    task automatic prep_words();
        logic [W-1:0] w;
        exp_bits.delete();
        exp_sum = '0;
        for (int i = 0; i < NWORDS; i++) begin
            w = words[i];
            for (int b = W - 1; b >= 0; b--) begin
                if (exp_bits.size() < TOTAL) exp_bits.push_back(w[b]);
                else w[b] = 1'b0;
            end
            exp_sum = exp_sum ^ w;
        end
`ifdef CFG_CHECKSUM_EN
        expected_sum = exp_sum;
`endif
    endtask

    task automatic do_start(input logic [RW-1:0] rc);
        start      = 1'b1;
        run_cycles = rc;
        tick();
        start      = 1'b0;
    endtask

    // Feed words[0..n-1] through valid/ready; optionally withhold valid for stall_len
    // LOAD cycles before word stall_idx, and pulse start while busy (must be ignored).
    task automatic load_words(input int n, input int stall_idx, input int stall_len,
                              input bit poke_start, input string name);
        int idx = 0;
        int stall_left = stall_len;
        int budget = 0;
        while (idx < n && budget < 3000) begin
            if (idx == stall_idx && stall_left > 0 && in_ready === 1'b1) begin
                in_valid = 1'b0;
                stall_left--;
            end else begin
                in_valid = 1'b1;
                in_data  = words[idx];
            end
            start = (poke_start && idx == 3) ? 1'b1 : 1'b0;
            tick();
            if (last_acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if (idx != n) begin
            failures++;
            $display("FAIL %s_load_timeout accepted=%0d required=%0d", name, idx, n);
        end
    endtask

    task automatic wait_run_done(input string name);
        int n = 0;
        while (run_done !== 1'b1 && n < 800) begin
            tick();
            n++;
        end
        checks++;
        if (run_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_run_done_timeout got=%b required=1", name, run_done);
        end
    endtask

    function automatic int bit_mismatches();
        int m = 0;
        for (int i = 0; i < TOTAL; i++)
            if (i >= cap_bits.size() || cap_bits[i] != exp_bits[i]) m++;
        return m;
    endfunction

    task automatic test_reset();
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'hDEAD_BEEF;
        start      = 1'b0;
        abort      = 1'b0;
        run_cycles = '0;
`ifdef CFG_CHECKSUM_EN
        expected_sum = '0;
`endif
        repeat (2) @(posedge clock);
        #1;
        checks++; if (in_ready !== 1'b0)         begin failures++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
        checks++; if (cgra_reset !== 1'b1)       begin failures++; $display("FAIL reset_cgra_reset got=%b required=1", cgra_reset); end
        checks++; if (config_enable !== 1'b0)    begin failures++; $display("FAIL reset_config_enable got=%b required=0", config_enable); end
        checks++; if (config_bitstream !== 1'b0) begin failures++; $display("FAIL reset_bitstream got=%b required=0", config_bitstream); end
        checks++; if ({busy, config_done, run_done} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b required=000", {busy, config_done, run_done});
        end
        reset = 1'b0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0 || config_enable !== 1'b0) begin
            failures++; $display("FAIL idle_no_accept got=%b%b required=00", in_ready, config_enable);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_load();
        for (int i = 0; i < NWORDS - 1; i++) words[i] = 32'hFFFF_FFFF;
        words[NWORDS-1] = 32'hAAAA_FFFF;
        prep_words();
        mon_clear();
        do_start(5);
        load_words(NWORDS, -1, 0, 1'b0, "full");
        wait_run_done("full");
        begin
            logic [16:0] tail = '0;
            if (cap_bits.size() >= TOTAL)
                for (int i = 0; i < 17; i++) tail[16-i] = cap_bits[TOTAL-17+i];
            checks++; if (tail !== 17'h15555) begin failures++; $display("FAIL full_tail17 got=%h required=15555", tail); end
        end
        checks++; if (en_cnt != TOTAL) begin failures++; $display("FAIL full_enable_cycles got=%0d required=%0d", en_cnt, TOTAL); end
        checks++; if (bit_mismatches() != 0) begin failures++; $display("FAIL full_bits mismatching=%0d required=0", bit_mismatches()); end
        checks++; if (first_en != first_acc + 1) begin failures++; $display("FAIL full_first_bit_latency got=%0d required=%0d", first_en - first_acc, 1); end
        checks++; if (done_first != last_en + 1) begin failures++; $display("FAIL full_config_done_rise got=%0d required=%0d", done_first, last_en + 1); end
        checks++; if ((last_en - first_en + 1) - en_cnt != NWORDS - 1) begin
            failures++; $display("FAIL full_gaps got=%0d required=%0d", (last_en - first_en + 1) - en_cnt, NWORDS - 1);
        end
        checks++; if (off_bit_err != 0) begin failures++; $display("FAIL full_bit_when_disabled got=%0d required=0", off_bit_err); end
        checks++; if (run_low != 5) begin failures++; $display("FAIL full_run_cycles got=%0d required=5", run_low); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < NWORDS - 1; i++) words[i] = 32'hFFFF_FFFF;
        words[NWORDS-1] = 32'hAAAA_FFFF;
        prep_words();
        mon_clear();
        do_start(2);
        load_words(NWORDS, 4, 3, 1'b0, "stall");
        wait_run_done("stall");
        checks++; if (en_cnt != TOTAL) begin failures++; $display("FAIL stall_enable_cycles got=%0d required=%0d", en_cnt, TOTAL); end
        checks++; if (bit_mismatches() != 0) begin failures++; $display("FAIL stall_bits mismatching=%0d required=0", bit_mismatches()); end
        checks++; if ((last_en - first_en + 1) - en_cnt != NWORDS - 1 + 3) begin
            failures++; $display("FAIL stall_gaps got=%0d required=%0d", (last_en - first_en + 1) - en_cnt, NWORDS + 2);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int rc   = $urandom_range(1, 20);
            int sidx = $urandom_range(1, NWORDS - 1);
            int slen = $urandom_range(0, 6);
            for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
            prep_words();
            mon_clear();
            do_start(RW'(rc));
            load_words(NWORDS, sidx, slen, 1'b1, "random");
            wait_run_done("random");
            checks++; if (bit_mismatches() != 0) begin failures++; $display("FAIL random_bits round=%0d mismatching=%0d required=0", r, bit_mismatches()); end
            checks++; if ((last_en - first_en + 1) - en_cnt != NWORDS - 1 + slen) begin
                failures++; $display("FAIL random_gaps round=%0d got=%0d required=%0d", r, (last_en - first_en + 1) - en_cnt, NWORDS - 1 + slen);
            end
            checks++; if (run_low != rc) begin failures++; $display("FAIL random_run_cycles got=%0d required=%0d", run_low, rc); end
        end
    endtask

    task automatic test_run_zero();
        for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
        prep_words();
        mon_clear();
        do_start(0);
        load_words(NWORDS, -1, 0, 1'b0, "run0");
        wait_run_done("run0");
        checks++; if (run_low != 1) begin failures++; $display("FAIL run0_cycles got=%0d required=1", run_low); end
        repeat (4) tick();
        checks++; if ({run_done, cgra_reset, busy, config_done} !== 4'b1001) begin
            failures++; $display("FAIL done_hold got=%b required=1001", {run_done, cgra_reset, busy, config_done});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({run_done, cgra_reset, config_done} !== 3'b010) begin
            failures++; $display("FAIL abort_from_done got=%b required=010", {run_done, cgra_reset, config_done});
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
        prep_words();
        mon_clear();
        do_start(4);
        load_words(7, -1, 0, 1'b0, "abort_part");
        repeat (10) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++; if ({busy, cgra_reset, config_done, config_enable, in_ready} !== 5'b01000) begin
            failures++; $display("FAIL abort_midword got=%b required=01000", {busy, cgra_reset, config_done, config_enable, in_ready});
        end
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_beats_start got=%b required=0", in_ready); end
        for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
        prep_words();
        mon_clear();
        do_start(3);
        load_words(NWORDS, -1, 0, 1'b0, "reload");
        wait_run_done("reload");
        checks++; if (bit_mismatches() != 0 || en_cnt != TOTAL) begin
            failures++; $display("FAIL reload_bits mismatching=%0d enables=%0d required=0/%0d", bit_mismatches(), en_cnt, TOTAL);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
        prep_words();
        mon_clear();
        do_start(4);
        load_words(3, -1, 0, 1'b0, "areset");
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        checks++; if ({config_enable, cgra_reset, busy, in_ready} !== 4'b0100) begin
            failures++; $display("FAIL async_reset got=%b required=0100", {config_enable, cgra_reset, busy, in_ready});
        end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || config_enable !== 1'b0) begin
            failures++; $display("FAIL after_async_reset got=%b%b required=00", busy, config_enable);
        end
    endtask

`ifdef CFG_CHECKSUM_EN
    task automatic test_checksum();
        int n;
        for (int i = 0; i < NWORDS; i++) words[i] = $urandom();
        prep_words();
        mon_clear();
        do_start(2);
        load_words(NWORDS, -1, 0, 1'b0, "csum_good");
        wait_run_done("csum_good");
        checks++; if (checksum_ok !== 1'b1) begin failures++; $display("FAIL checksum_good got=%b required=1", checksum_ok); end
        prep_words();
        expected_sum = exp_sum ^ 32'h8000_0000;
        mon_clear();
        do_start(2);
        load_words(NWORDS, -1, 0, 1'b0, "csum_bad");
        n = 0;
        while (config_done !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        checks++; if ({checksum_ok, busy, cgra_reset, run_done} !== 4'b0010 || run_low != 0) begin
            failures++; $display("FAIL checksum_bad got=%b run=%0d required=0010 run=0", {checksum_ok, busy, cgra_reset, run_done}, run_low);
        end
    endtask
`endif

    initial begin
        ncyc = 0;
        mon_clear();
        test_reset();
        test_full_load();
        test_stall();
        test_random();
        test_run_zero();
        test_abort();
        test_async_reset();
`ifdef CFG_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
